keypad_scan_fifo: RTL and testbench
===================================

KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

Interface
REQ-001 Parameter ROWS, default 4, SHALL set the number of row inputs (2..8).
REQ-002 Parameter COLS, default 4, SHALL set the number of column drive outputs (2..8).
REQ-003 Parameter SETTLE_CYC, default 1000, SHALL set the column dwell in clk cycles before sampling (minimum 3).
REQ-004 Parameter DEB_SCANS, default 4, SHALL set the number of consecutive differing scans needed to accept a key change (minimum 1).
REQ-005 Parameter DEPTH, default 8, SHALL set the event FIFO depth (power of two, minimum 2).
REQ-006 Parameter REPORT_RELEASE, default 0, SHALL enable release events when set to 1.
REQ-007 Derived widths SHALL be CODE_W = clog2(ROWS*COLS) and CNT_W = clog2(DEPTH)+1.
REQ-008 Port list SHALL be clk (input, 1, sole clock), followed by rst (input, 1, asynchronous active-low reset).
REQ-009 Port col SHALL be an output of width COLS carrying the one-hot, active-high column drive.
REQ-010 Port fila SHALL be an input of width ROWS carrying the asynchronous, active-high rows (1 = key pressed).
REQ-011 Port key_valid SHALL be a 1-bit output that is high when the FIFO is non-empty.
REQ-012 Port key_ready SHALL be a 1-bit input; the consumer pops the FIFO head when it and key_valid are both high.
REQ-013 Port key_code SHALL be an output of width CODE_W+1: the MSB is the release flag (0 = press) and the low bits are row*COLS+col.
REQ-014 Port fifo_count SHALL be an output of width CNT_W giving the current FIFO occupancy.
REQ-015 Port overflow SHALL be a 1-bit sticky output indicating a dropped event.
REQ-016 Port ovf_clr SHALL be a 1-bit input that clears overflow synchronously.

Function
REQ-017 fila SHALL pass through a two-flop synchroniser before any use.
REQ-018 The scan FSM SHALL have states DRIVE, SAMPLE and UPDATE, and SHALL leave reset in DRIVE with column index 0.
- DRIVE: held for SETTLE_CYC cycles.
- SAMPLE: lasts 1 cycle and captures the synchronised fila into row_snap.
- UPDATE: lasts ROWS cycles and processes row r = 0..ROWS-1 in ascending order, one row per cycle.
REQ-019 On the last UPDATE cycle, the column index SHALL advance modulo COLS and the FSM SHALL return to DRIVE.
REQ-020 The column period SHALL be SETTLE_CYC+1+ROWS cycles, and col SHALL be constant for the whole period.
REQ-021 Each key SHALL hold a stable bit s and a counter c, and the UPDATE step for sample x SHALL behave as follows:
- x == s: c <= 0.
- x != s and c+1 < DEB_SCANS: c <= c+1.
- x != s and c+1 == DEB_SCANS: s <= x, c <= 0, and an event is generated.
REQ-022 A 0->1 change of s SHALL push a press code; a 1->0 change SHALL push a release code only if REPORT_RELEASE = 1 and SHALL otherwise push nothing.
REQ-023 The FIFO SHALL be first-word fall-through: key_code equals the head whenever key_valid = 1, and its value is don't-care when empty.
REQ-024 On a push while full without a same-cycle pop, the event SHALL be dropped, fifo_count SHALL be unchanged, and overflow SHALL be set.
REQ-025 On a push and a pop in the same cycle (full or not), both SHALL occur and fifo_count SHALL be unchanged, with no overflow.
REQ-026 On a pop while empty, nothing SHALL change.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH.
REQ-028 If ovf_clr and a new overflow coincide, overflow SHALL remain 1 (set wins).
REQ-029 Pushes and pops SHALL update fifo_count with one-cycle latency, so key_valid rises on the cycle after the push.
REQ-030 The block SHALL add no ghosting or rollover filtering; every debounced key change SHALL be reported independently.

Reset
REQ-031 While rst = 0, all of the following SHALL hold asynchronously:
- col = one-hot column 0.
- FSM in DRIVE, with the dwell counter at 0.
- All s = 0 and all c = 0.
- FIFO pointers at 0, fifo_count = 0, key_valid = 0.
- overflow = 0.
- Synchroniser flops at 0.
REQ-032 Reset asserted mid-scan or mid-UPDATE SHALL discard pending events without emitting a partial event.
REQ-033 Scanning SHALL restart at column 0 on the first clk edge after rst returns high.

Verification (ROWS=4, COLS=4, SETTLE_CYC=3, DEB_SCANS=2, DEPTH=4; column period 8 cycles, scan 32 cycles)
REQ-034 Press: hold fila[1] high only while col[2] is active, for 2 scans, with key_ready = 0 -> exactly one event; key_code = 0_0110, key_valid = 1, fifo_count = 1; pulse key_ready for 1 cycle -> fifo_count = 0, key_valid = 0.
REQ-035 Bounce: key (row 3, col 0) high for 1 scan, then low -> no event; fifo_count stays 0.
REQ-036 Same-column ordering: rows 0 and 3 held under col 1 -> codes 1 then 13 appear, in that order, in consecutive FIFO entries.
REQ-037 Overflow: with REPORT_RELEASE = 1 and key_ready = 0, toggle key 0 to produce 5 events -> fifo_count = 4, overflow = 1, entries are 0_0000, 1_0000, 0_0000, 1_0000; ovf_clr -> overflow = 0; repeating with key_ready = 1 on the 5th push cycle -> overflow stays 0.
REQ-038 Reset mid-operation: rst low for 1 cycle while fifo_count = 2 and an UPDATE is in progress -> immediately fifo_count = 0, key_valid = 0, col = 0001; no event is emitted after release until new debounced presses occur.

Source files
------------

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo
//   Scans a ROWS x COLS switch matrix one column at a time, debounces every
//   key independently and queues press (and optionally release) events in a
//   first-word fall-through FIFO.
//
// Ports
//   clk        : sole clock
//   rst        : asynchronous active-low reset
//   col        : one-hot, active-high column drive (COLS bits)
//   fila       : asynchronous, active-high row returns (ROWS bits, 1 = pressed)
//   key_valid  : FIFO non-empty
//   key_ready  : consumer pops the head when key_valid is also high
//   key_code   : FIFO head, {release_flag, row*COLS+col}
//   fifo_count : current FIFO occupancy
//   overflow   : sticky, set when an event is dropped on a full FIFO
//   ovf_clr    : synchronous clear of overflow (a same-cycle drop wins)
module keypad_scan_fifo #(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SETTLE_CYC     = 1000,
  parameter int unsigned DEB_SCANS      = 4,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned REPORT_RELEASE = 0,
  parameter int unsigned CODE_W         = $clog2(ROWS * COLS),
  parameter int unsigned CNT_W          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [COLS-1:0]   col,
  input  logic [ROWS-1:0]   fila,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [CODE_W:0]   key_code,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned NKEYS   = ROWS * COLS;
  localparam int unsigned RIDX_W  = $clog2(ROWS);
  localparam int unsigned CIDX_W  = $clog2(COLS);
  localparam int unsigned DWELL_W = $clog2(SETTLE_CYC);
  localparam int unsigned DEB_W   = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
  localparam int unsigned PTR_W   = $clog2(DEPTH);

  localparam logic [1:0] ST_DRIVE  = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SETTLE_CYC - 1);
  localparam logic [RIDX_W-1:0]  ROW_LAST   = RIDX_W'(ROWS - 1);
  localparam logic [CIDX_W-1:0]  COL_LAST   = CIDX_W'(COLS - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_SCANS - 1);
  localparam logic [CNT_W-1:0]   FULL_CNT   = CNT_W'(DEPTH);

  // Row synchroniser
  logic [ROWS-1:0] fila_s1_q, fila_s2_q;

  // Scan sequencer
  logic [1:0]         state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [RIDX_W-1:0]  row_idx_q, row_idx_d;
  logic [CIDX_W-1:0]  col_idx_q, col_idx_d;
  logic [COLS-1:0]    col_q, col_d;
  logic [ROWS-1:0]    row_snap_q, row_snap_d;

  // Per-key debounce state
  logic [NKEYS-1:0]            stable_q, stable_d;
  logic [NKEYS-1:0][DEB_W-1:0] cnt_q, cnt_d;

  // Event FIFO
  logic [CODE_W:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
  logic               overflow_q, overflow_d;

  logic [CODE_W-1:0]  key_idx;
  logic               sample_bit;
  logic               push_req;
  logic [CODE_W:0]    push_code;
  logic               fifo_empty, fifo_full;
  logic               pop, push_ok, drop;

  // ---------------------------------------------------------------------
  // Scan sequencer: DRIVE (SETTLE_CYC) -> SAMPLE (1) -> UPDATE (ROWS)
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    row_idx_d  = row_idx_q;
    col_idx_d  = col_idx_q;
    col_d      = col_q;
    row_snap_d = row_snap_q;
    case (state_q)
      ST_DRIVE: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          state_d = ST_SAMPLE;
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end
      ST_SAMPLE: begin
        row_snap_d = fila_s2_q;
        row_idx_d  = '0;
        state_d    = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (row_idx_q == ROW_LAST) begin
          row_idx_d = '0;
          state_d   = ST_DRIVE;
          col_d     = {col_q[COLS-2:0], col_q[COLS-1]};
          if (col_idx_q == COL_LAST) begin
            col_idx_d = '0;
          end else begin
            col_idx_d = col_idx_q + CIDX_W'(1);
          end
        end else begin
          row_idx_d = row_idx_q + RIDX_W'(1);
        end
      end
      default: begin
        state_d   = ST_DRIVE;
        dwell_d   = '0;
        row_idx_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Debounce: one key per UPDATE cycle
  // ---------------------------------------------------------------------
  always_comb begin
    key_idx    = CODE_W'(row_idx_q) * CODE_W'(COLS) + CODE_W'(col_idx_q);
    sample_bit = row_snap_q[row_idx_q];
    stable_d   = stable_q;
    cnt_d      = cnt_q;
    push_req   = 1'b0;
    push_code  = '0;
    if (state_q == ST_UPDATE) begin
      if (sample_bit == stable_q[key_idx]) begin
        cnt_d[key_idx] = '0;
      end else if (cnt_q[key_idx] != DEB_LAST) begin
        cnt_d[key_idx] = cnt_q[key_idx] + DEB_W'(1);
      end else begin
        stable_d[key_idx] = sample_bit;
        cnt_d[key_idx]    = '0;
        push_req          = sample_bit || (REPORT_RELEASE != 0);
        push_code         = {~sample_bit, key_idx};
      end
    end
  end

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  always_comb begin
    fifo_empty = (fifo_count_q == '0);
    fifo_full  = (fifo_count_q == FULL_CNT);
    pop        = key_ready && !fifo_empty;
    // When full, a same-cycle pop frees the head slot, which is exactly
    // the slot the write pointer addresses, so the push can proceed.
    push_ok    = push_req && (!fifo_full || pop);
    drop       = push_req && fifo_full && !pop;

    wr_ptr_d     = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (push_ok && !pop) begin
      fifo_count_d = fifo_count_q + CNT_W'(1);
    end else if (pop && !push_ok) begin
      fifo_count_d = fifo_count_q - CNT_W'(1);
    end

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fila_s1_q    <= '0;
      fila_s2_q    <= '0;
      state_q      <= ST_DRIVE;
      dwell_q      <= '0;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      col_q        <= COLS'(1);
      row_snap_q   <= '0;
      stable_q     <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      fila_s1_q    <= fila;
      fila_s2_q    <= fila_s1_q;
      state_q      <= state_d;
      dwell_q      <= dwell_d;
      row_idx_q    <= row_idx_d;
      col_idx_q    <= col_idx_d;
      col_q        <= col_d;
      row_snap_q   <= row_snap_d;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage array carries no reset; its contents are only observed
  // through occupied slots.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_code;
    end
  end

  assign col        = col_q;
  assign key_valid  = !fifo_empty;
  assign key_code   = mem_q[rd_ptr_q];
  assign fifo_count = fifo_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// tb_keypad_scan_fifo
//   Directed bench for keypad_scan_fifo with ROWS=4, COLS=4, SETTLE_CYC=3,
//   DEB_SCANS=2, DEPTH=4. Two instances share clock, reset and the modelled
//   key matrix: u_nr ignores releases, u_rr reports them. Edge numbers are
//   counted from reset release; column c of every 32-cycle scan captures
//   rows at edge 32s+8c+4 and processes row r at edge 32s+8c+5+r.
module tb_keypad_scan_fifo;

  logic        clk;
  logic        rst;
  logic [3:0]  fila;
  logic [3:0]  col_nr, col_rr;
  logic        kr0, kr1, oc0, oc1;
  logic        valid0, valid1;
  logic [4:0]  code0, code1;
  logic [2:0]  cnt0, cnt1;
  logic        ovf0, ovf1;

  logic [3:0][3:0] key_down;   // [row][col]
  int unsigned     ed;
  int              checks;
  int              errors;
  logic [4:0]      exp_ovf [4];

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SETTLE_CYC(3), .DEB_SCANS(2), .DEPTH(4), .REPORT_RELEASE(0)
  ) u_nr (
    .clk(clk), .rst(rst), .col(col_nr), .fila(fila),
    .key_valid(valid0), .key_ready(kr0), .key_code(code0),
    .fifo_count(cnt0), .overflow(ovf0), .ovf_clr(oc0)
  );

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SETTLE_CYC(3), .DEB_SCANS(2), .DEPTH(4), .REPORT_RELEASE(1)
  ) u_rr (
    .clk(clk), .rst(rst), .col(col_rr), .fila(fila),
    .key_valid(valid1), .key_ready(kr1), .key_code(code1),
    .fifo_count(cnt1), .overflow(ovf1), .ovf_clr(oc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive switch matrix driven by the column outputs
  always_comb begin
    fila = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_down[r][c] && col_nr[c]) fila[r] = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      ed++;
    end
    #1;
  endtask

  task automatic align16();
    while (ed % 32 != 16) tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; ed = 0;
    rst = 1'b0; kr0 = 1'b0; kr1 = 1'b0; oc0 = 1'b0; oc1 = 1'b0;
    key_down = '0;
    exp_ovf[0] = 5'b00000; exp_ovf[1] = 5'b10000;
    exp_ovf[2] = 5'b00000; exp_ovf[3] = 5'b10000;
    key_down[1][2] = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_col_nr", col_nr, 4'b0001);
    check("rst_col_rr", col_rr, 4'b0001);
    check("rst_cnt", cnt0, 0);
    check("rst_valid", valid0, 0);
    check("rst_ovf", ovf1, 0);
    @(negedge clk); rst = 1'b1; ed = 0;

    // Press of (row1,col2), debounced on the second scan at edge 54
    tick(8);
    check("col_step", col_nr, 4'b0010);
    tick(45);
    check("press_pre_cnt", cnt0, 0);
    tick(1);
    check("press_cnt", cnt0, 1);
    check("press_valid", valid0, 1);
    check("press_code", code0, 5'b00110);
    check("press_cnt_rr", cnt1, 1);
    check("press_code_rr", code1, 5'b00110);
    kr0 = 1'b1; kr1 = 1'b1;
    tick(1);
    kr0 = 1'b0; kr1 = 1'b0;
    check("pop_cnt", cnt0, 0);
    check("pop_valid", valid0, 0);
    check("pop_cnt_rr", cnt1, 0);

    // Release: only the release-reporting instance queues it
    key_down[1][2] = 1'b0;
    tick(105);
    check("norel_cnt", cnt0, 0);
    check("rel_cnt_rr", cnt1, 1);
    check("rel_code_rr", code1, 5'b10110);
    kr0 = 1'b1; kr1 = 1'b1;
    tick(1);
    kr0 = 1'b0; kr1 = 1'b0;
    check("empty_pop_cnt", cnt0, 0);
    check("empty_pop_valid", valid0, 0);
    check("rel_pop_rr", cnt1, 0);

    // Bounce: (row3,col0) seen in exactly one scan
    align16();
    key_down[3][0] = 1'b1;
    tick(32);
    key_down[3][0] = 1'b0;
    tick(96);
    check("bounce_cnt", cnt0, 0);
    check("bounce_cnt_rr", cnt1, 0);

    // Same-column ordering: rows 0 and 3 under col 1
    key_down[0][1] = 1'b1; key_down[3][1] = 1'b1; kr1 = 1'b1;
    tick(66);
    check("order_cnt", cnt0, 2);
    check("order_first", code0, 5'd1);
    kr0 = 1'b1;
    tick(1);
    check("order_cnt1", cnt0, 1);
    check("order_second", code0, 5'd13);
    tick(1);
    kr0 = 1'b0;
    check("order_cnt0", cnt0, 0);
    key_down[0][1] = 1'b0; key_down[3][1] = 1'b0;
    tick(96);
    check("order_norel", cnt0, 0);

    // Overflow: five toggles of key 0 into a 4-deep FIFO, clear coincides with drop
    kr1 = 1'b0; kr0 = 1'b1;
    align16();
    for (int i = 0; i < 4; i++) begin
      key_down[0][0] = ~key_down[0][0];
      tick(64);
    end
    key_down[0][0] = ~key_down[0][0];
    tick(52);
    check("full_cnt", cnt1, 4);
    check("full_ovf", ovf1, 0);
    oc1 = 1'b1;
    tick(1);
    oc1 = 1'b0;
    check("ovf_cnt", cnt1, 4);
    check("ovf_set", ovf1, 1);
    check("ovf_valid", valid1, 1);
    check("ovf_nr", ovf0, 0);
    for (int i = 0; i < 4; i++) begin
      check("ovf_entry", code1, exp_ovf[i]);
      kr1 = 1'b1;
      tick(1);
      kr1 = 1'b0;
    end
    check("ovf_drained", cnt1, 0);
    check("ovf_drained_valid", valid1, 0);
    check("ovf_sticky", ovf1, 1);
    oc1 = 1'b1;
    tick(1);
    oc1 = 1'b0;
    check("ovf_clr", ovf1, 0);

    // Same again, but pop on the fifth push: full push+pop, no overflow
    align16();
    for (int i = 0; i < 4; i++) begin
      key_down[0][0] = ~key_down[0][0];
      tick(64);
    end
    key_down[0][0] = ~key_down[0][0];
    tick(52);
    check("full2_cnt", cnt1, 4);
    check("full2_head", code1, 5'b10000);
    kr1 = 1'b1;
    tick(1);
    kr1 = 1'b0;
    check("pp_cnt", cnt1, 4);
    check("pp_ovf", ovf1, 0);
    check("pp_head", code1, 5'b00000);
    kr1 = 1'b1;
    tick(4);
    kr1 = 1'b0;
    check("pp_drained", cnt1, 0);

    // Reset mid-UPDATE with two queued events
    kr0 = 1'b0; kr1 = 1'b1;
    align16();
    key_down[0][1] = 1'b1; key_down[3][1] = 1'b1;
    tick(70);
    check("mid_cnt", cnt0, 2);
    rst = 1'b0;
    #1;
    check("rstm_cnt", cnt0, 0);
    check("rstm_valid", valid0, 0);
    check("rstm_col", col_nr, 4'b0001);
    @(posedge clk);
    @(negedge clk); rst = 1'b1; ed = 0;
    tick(8);
    check("rstm_col_step", col_nr, 4'b0010);
    tick(36);
    check("rstm_quiet", cnt0, 0);
    tick(1);
    check("rstm_first_cnt", cnt0, 1);
    check("rstm_first_code", code0, 5'd1);
    tick(3);
    check("rstm_second_cnt", cnt0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
